// File: rtl/booth_multiplier_sequencer_if.sv
// Bundles the start/operand/result handshake and the adder/subtracter link of booth_multiplier_sequencer.
// Optional op_count signal appears only when BOOTH_OP_COUNT_EN is defined.
interface booth_multiplier_sequencer_if #(
  parameter int WIDTH = 4
);
  logic                   start;
  logic [WIDTH-1:0]       multiplicand;
  logic [WIDTH-1:0]       multiplier;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     product;
  logic [WIDTH-1:0]       add_a;
  logic [WIDTH-1:0]       add_b;
  logic                   add_s;
  logic [WIDTH-1:0]       add_sum;
  logic                   add_v;
`ifdef BOOTH_OP_COUNT_EN
  logic [$clog2(WIDTH+1)-1:0] op_count;
`endif

  modport master (
    output start, multiplicand, multiplier, add_sum, add_v,
    input  busy, done, product, add_a, add_b, add_s
`ifdef BOOTH_OP_COUNT_EN
    , input op_count
`endif
  );

  modport slave (
    input  start, multiplicand, multiplier, add_sum, add_v,
    output busy, done, product, add_a, add_b, add_s
`ifdef BOOTH_OP_COUNT_EN
    , output op_count
`endif
  );
endinterface

// File: rtl/booth_multiplier_sequencer.sv
// Radix-2 Booth sequential multiplier controller driving an external adder/subtracter.
// Define BOOTH_OP_COUNT_EN to add the op_count output (number of add/sub steps used).
module booth_multiplier_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  booth_multiplier_sequencer_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic               q1_q, q1_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
`ifdef BOOTH_OP_COUNT_EN
  logic [CW-1:0]      ops_q, ops_d;
`endif

  logic               useSum;
  logic [WIDTH-1:0]   r;
  logic               sign;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
`ifdef BOOTH_OP_COUNT_EN
      ops_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
`ifdef BOOTH_OP_COUNT_EN
      ops_q   <= ops_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
`ifdef BOOTH_OP_COUNT_EN
    ops_d   = ops_q;
`endif
    // The sign shifted in comes from the true result, which recovers an overflowed add/sub.
    useSum  = q_q[0] ^ q1_q;
    r       = useSum ? bus.add_sum : a_q;
    sign    = useSum ? (bus.add_sum[WIDTH-1] ^ bus.add_v) : a_q[WIDTH-1];

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = CALC;
          a_d     = '0;
          q_d     = bus.multiplier;
          m_d     = bus.multiplicand;
          q1_d    = 1'b0;
          cnt_d   = '0;
`ifdef BOOTH_OP_COUNT_EN
          ops_d   = '0;
`endif
        end
      end
      CALC: begin
        a_d   = {sign, r[WIDTH-1:1]};
        q_d   = {r[0], q_q[WIDTH-1:1]};
        q1_d  = q_q[0];
        cnt_d = cnt_q + 1'b1;
`ifdef BOOTH_OP_COUNT_EN
        if (useSum) ops_d = ops_q + 1'b1;
`endif
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          prod_d  = {a_d, q_d};
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy    = (state_q == CALC);
  assign bus.done    = (state_q == DONE);
  assign bus.product = prod_q;
  assign bus.add_a   = a_q;
  assign bus.add_b   = m_q;
  assign bus.add_s   = q_q[0] & ~q1_q;
`ifdef BOOTH_OP_COUNT_EN
  assign bus.op_count = ops_q;
`endif
endmodule

// File: tb/tb_booth_multiplier_sequencer.sv
// Scoreboard bench for booth_multiplier_sequencer with a behavioural adder/subtracter attached.
// Expected products come from plain signed multiplication of the operands.
module tb_booth_multiplier_sequencer;
  localparam int W = 4;

  typedef struct {
    logic [2*W-1:0] prod;
    int             ops;
    string          tag;
  } exp_t;

  logic clk;
  logic rst;
  exp_t expQ[$];
  int   compared;
  int   mismatched;

  booth_multiplier_sequencer_if #(.WIDTH(W)) bus ();

  booth_multiplier_sequencer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the attached adder/subtracter: wraps to W bits, flags signed overflow.
  always_comb begin
    int av, bv, res;
    av = $signed(bus.add_a);
    bv = $signed(bus.add_b);
    res = bus.add_s ? (av - bv) : (av + bv);
    bus.add_sum = res[W-1:0];
    bus.add_v   = (res > (2 ** (W - 1)) - 1) || (res < -(2 ** (W - 1)));
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t modelOp(input logic [W-1:0] m, input logic [W-1:0] q, input string tag);
    exp_t e;
    int   mi, qi, p, prev;
    mi = $signed(m);
    qi = $signed(q);
    p  = mi * qi;
    e.prod = p[2*W-1:0];
    e.ops  = 0;
    prev   = 0;
    for (int i = 0; i < W; i++) begin
      if (int'(q[i]) != prev) e.ops++;
      prev = int'(q[i]);
    end
    e.tag = tag;
    return e;
  endfunction

  // Monitor: every done pulse is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpectedDone: got done=1 product=%0h, expected no done", bus.product);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput({"product ", e.tag}, 64'(bus.product), 64'(e.prod));
        checkOutput({"busyInDone ", e.tag}, 64'(bus.busy), 64'd0);
`ifdef BOOTH_OP_COUNT_EN
        checkOutput({"opCount ", e.tag}, 64'(bus.op_count), 64'(e.ops));
`endif
      end
    end
  end

  // Called at a negedge in IDLE; returns at the negedge of the first IDLE cycle after DONE.
  task automatic applyStimulus(input logic [W-1:0] m, input logic [W-1:0] q, input string tag);
    int k;
    bus.start        = 1'b1;
    bus.multiplicand = m;
    bus.multiplier   = q;
    expQ.push_back(modelOp(m, q, tag));
    @(negedge clk);
    bus.start = 1'b0;
    k = 1;
    checkOutput({"busyCycle1 ", tag}, 64'(bus.busy), 64'd1);
    while (!bus.done && k < 4 * W + 4) begin
      @(negedge clk);
      k++;
    end
    checkOutput({"doneLatency ", tag}, 64'(bus.done ? k : -1), 64'(W + 1));
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    compared         = 0;
    mismatched       = 0;
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    repeat (2) @(negedge clk);
    checkOutput("resetBusy", 64'(bus.busy), 64'd0);
    checkOutput("resetDone", 64'(bus.done), 64'd0);
    checkOutput("resetProduct", 64'(bus.product), 64'd0);
    checkOutput("resetAddA", 64'(bus.add_a), 64'd0);
    checkOutput("resetAddB", 64'(bus.add_b), 64'd0);
    checkOutput("resetAddS", 64'(bus.add_s), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(4'b0011, 4'b0010, "3x2");
    applyStimulus(4'b1101, 4'b0010, "-3x2");
    applyStimulus(4'b1000, 4'b1000, "-8x-8");
    applyStimulus(4'b0111, 4'b1000, "7x-8");
    applyStimulus(4'b0001, 4'b0001, "1x1backToBack");

    // Start during CALC cycle 2 must be ignored.
    bus.start = 1'b1; bus.multiplicand = 4'b0011; bus.multiplier = 4'b0010;
    expQ.push_back(modelOp(4'b0011, 4'b0010, "midStart3x2"));
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = 4'b0111; bus.multiplier = 4'b0101;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    while (!bus.done && k < 4 * W) begin
      @(negedge clk);
      k++;
    end
    checkOutput("midStartDoneSeen", 64'(bus.done), 64'd1);
    repeat (W + 3) @(negedge clk);

    // Reset during CALC cycle 3 aborts without a done pulse.
    bus.start = 1'b1; bus.multiplicand = 4'b0101; bus.multiplier = 4'b0110;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abortBusy", 64'(bus.busy), 64'd0);
    checkOutput("abortDone", 64'(bus.done), 64'd0);
    checkOutput("abortProduct", 64'(bus.product), 64'd0);
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      checkOutput("abortNoDone", 64'(bus.done), 64'd0);
    end

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] rm, rq;
      rm = W'($urandom);
      rq = W'($urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      applyStimulus(rm, rq, $sformatf("rand%0d", i));
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboardDrained", 64'(expQ.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
